// File: rtl/ysyx_22041071_hazard_unit.sv
// ID-stage hazard controller: shadow EX/MEM/WB scoreboard, forwarding selects, load-use and mul/div holds.
// Optional perf counters (perf_lu_cnt, perf_md_cnt) are built when YSYX_22041071_HAZARD_PERF_EN is defined.
module ysyx_22041071_hazard_unit #(
    parameter int MULDIV_LAT = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_rd,
    input  logic       id_reg_w_en,
    input  logic       id_is_load,
    input  logic       id_is_muldiv,
    input  logic       ex_ready,
    input  logic       flush,
    output logic       id_ready,
    output logic       id_fire,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       load_use_stall,
    output logic       muldiv_busy,
    output logic       ex_bubble
`ifdef YSYX_22041071_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_md_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MULDIV_LAT - 1);

    logic             ex_v_q,   ex_v_d,   mem_v_q,   mem_v_d,   wb_v_q,   wb_v_d;
    logic [4:0]       ex_rd_q,  ex_rd_d,  mem_rd_q,  mem_rd_d,  wb_rd_q,  wb_rd_d;
    logic             ex_wen_q, ex_wen_d, mem_wen_q, mem_wen_d, wb_wen_q, wb_wen_d;
    logic             ex_ld_q,  ex_ld_d,  mem_ld_q,  mem_ld_d,  wb_ld_q,  wb_ld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_wr, mem_wr, wb_wr, busy;

    function automatic logic [1:0] fwd_sel(
        input logic       use_src,
        input logic [4:0] src,
        input logic       ex_hit_ok,
        input logic [4:0] ex_rd,
        input logic       mem_w,
        input logic [4:0] mem_rd,
        input logic       wb_w,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src && (src != 5'd0)) begin
            if (ex_hit_ok && (ex_rd == src))        sel = 2'd1;
            else if (mem_w && (mem_rd == src))      sel = 2'd2;
            else if (wb_w && (wb_rd == src))        sel = 2'd3;
        end
        return sel;
    endfunction

    assign ex_wr  = ex_v_q  & ex_wen_q  & (ex_rd_q  != 5'd0);
    assign mem_wr = mem_v_q & mem_wen_q & (mem_rd_q != 5'd0);
    assign wb_wr  = wb_v_q  & wb_wen_q  & (wb_rd_q  != 5'd0);
    assign busy   = (cnt_q != '0);

    assign load_use_stall = id_valid & ex_wr & ex_ld_q &
                            ((id_use_rs & (id_rs == ex_rd_q)) | (id_use_rt & (id_rt == ex_rd_q)));
    assign id_ready    = ex_ready & ~load_use_stall & ~busy;
    assign id_fire     = id_valid & id_ready;
    assign muldiv_busy = busy;
    assign ex_bubble   = ~ex_v_q;

    // A load in EX has no data yet, so it is never an EX forwarding source.
    assign fwd_rs_sel = fwd_sel(id_use_rs, id_rs, ex_wr & ~ex_ld_q, ex_rd_q,
                                mem_wr, mem_rd_q, wb_wr, wb_rd_q);
    assign fwd_rt_sel = fwd_sel(id_use_rt, id_rt, ex_wr & ~ex_ld_q, ex_rd_q,
                                mem_wr, mem_rd_q, wb_wr, wb_rd_q);

    always_comb begin
        ex_v_d    = ex_v_q;
        ex_rd_d   = ex_rd_q;
        ex_wen_d  = ex_wen_q;
        ex_ld_d   = ex_ld_q;
        mem_v_d   = ex_v_q;
        mem_rd_d  = ex_rd_q;
        mem_wen_d = ex_wen_q;
        mem_ld_d  = ex_ld_q;
        wb_v_d    = mem_v_q;
        wb_rd_d   = mem_rd_q;
        wb_wen_d  = mem_wen_q;
        wb_ld_d   = mem_ld_q;
        cnt_d     = cnt_q;
        if (busy) begin
            // EX is occupied by the mul/div; a bubble drops into MEM behind it.
            mem_v_d = 1'b0;
            cnt_d   = cnt_q - 1'b1;
        end else begin
            ex_v_d   = id_fire & ~flush;
            ex_rd_d  = id_rd;
            ex_wen_d = id_reg_w_en;
            ex_ld_d  = id_is_load;
            if (id_fire && id_is_muldiv && !flush) cnt_d = LAT_M1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q  <= 1'b0;
            mem_v_q <= 1'b0;
            wb_v_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ex_v_q  <= ex_v_d;
            mem_v_q <= mem_v_d;
            wb_v_q  <= wb_v_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slot payloads are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        ex_rd_q   <= ex_rd_d;
        ex_wen_q  <= ex_wen_d;
        ex_ld_q   <= ex_ld_d;
        mem_rd_q  <= mem_rd_d;
        mem_wen_q <= mem_wen_d;
        mem_ld_q  <= mem_ld_d;
        wb_rd_q   <= wb_rd_d;
        wb_wen_q  <= wb_wen_d;
        wb_ld_q   <= wb_ld_d;
    end

`ifdef YSYX_22041071_HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_md_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lu_q <= '0;
            perf_md_q <= '0;
        end else begin
            if (id_valid && load_use_stall) perf_lu_q <= perf_lu_q + 32'd1;
            if (busy)                       perf_md_q <= perf_md_q + 32'd1;
        end
    end

    assign perf_lu_cnt = perf_lu_q;
    assign perf_md_cnt = perf_md_q;
`endif

endmodule

// File: tb/tb_ysyx_22041071_hazard_unit.sv
// Directed bench for ysyx_22041071_hazard_unit: vector table for hazard/forwarding, hand sequences for holds.
module tb_ysyx_22041071_hazard_unit;

    logic       clk = 1'b0;
    logic       reset, id_valid, id_use_rs, id_use_rt, id_reg_w_en, id_is_load, id_is_muldiv;
    logic       ex_ready, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_ready, id_fire, load_use_stall, muldiv_busy, ex_bubble;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef YSYX_22041071_HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_md_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22041071_hazard_unit #(.MULDIV_LAT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_w_en(id_reg_w_en),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .ex_ready(ex_ready), .flush(flush),
        .id_ready(id_ready), .id_fire(id_fire), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .load_use_stall(load_use_stall), .muldiv_busy(muldiv_busy), .ex_bubble(ex_bubble)
`ifdef YSYX_22041071_HAZARD_PERF_EN
        , .perf_lu_cnt(perf_lu_cnt), .perf_md_cnt(perf_md_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0] wb_rd, mem_rd, ex_rd;
        logic       mem_ld, ex_ld, ex_wen;
        logic [4:0] rs, rt;
        logic       use_rs, use_rt, exr;
        logic       stall, rdy;
        logic [1:0] frs, frt;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_rd = 0;
        id_reg_w_en = 0; id_is_load = 0; id_is_muldiv = 0; ex_ready = 1; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic fire(input logic [4:0] rd, input logic wen, input logic ld, input logic md);
        idle();
        id_valid = 1; id_rd = rd; id_reg_w_en = wen; id_is_load = ld; id_is_muldiv = md;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic present(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
        idle();
        id_valid = 1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt; id_rd = 5'd20;
        id_reg_w_en = 1;
    endtask

    initial begin
        int busy_cycles;
        reset = 1;
        idle();
        vt[0]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1};
        vt[1]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd3};
        vt[2]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        vt[3]  = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1};
        vt[4]  = '{5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        vt[5]  = '{5'd4, 5'd3, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};
        vt[6]  = '{5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd3};
        vt[7]  = '{5'd1, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 5'd6, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd3};
        vt[8]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2};
        vt[9]  = '{5'd1, 5'd4, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0};
        vt[10] = '{5'd3, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd3};

        // Reset state
        do_reset();
        chk("rst_busy", 32'(muldiv_busy), 32'd0);
        chk("rst_bubble", 32'(ex_bubble), 32'd1);
        chk("rst_fwd_rs", 32'(fwd_rs_sel), 32'd0);
        chk("rst_fwd_rt", 32'(fwd_rt_sel), 32'd0);
        chk("rst_stall", 32'(load_use_stall), 32'd0);

        // Vector table: fill WB, MEM, EX then present a reader in ID
        for (int i = 0; i < 11; i++) begin
            do_reset();
            fire(vt[i].wb_rd, 1'b1, 1'b0, 1'b0);
            fire(vt[i].mem_rd, 1'b1, vt[i].mem_ld, 1'b0);
            fire(vt[i].ex_rd, vt[i].ex_wen, vt[i].ex_ld, 1'b0);
            present(vt[i].rs, vt[i].use_rs, vt[i].rt, vt[i].use_rt);
            ex_ready = vt[i].exr;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(load_use_stall), 32'(vt[i].stall));
            chk($sformatf("v%0d_ready", i), 32'(id_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d_fire", i), 32'(id_fire), 32'(vt[i].rdy));
            chk($sformatf("v%0d_fwd_rs", i), 32'(fwd_rs_sel), 32'(vt[i].frs));
            chk($sformatf("v%0d_fwd_rt", i), 32'(fwd_rt_sel), 32'(vt[i].frt));
            idle();
        end

        // Load-use: ld x5 then add x6,x5,x7
        do_reset();
        fire(5'd5, 1'b1, 1'b1, 1'b0);
        present(5'd5, 1'b1, 5'd7, 1'b1);
        #1;
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        chk("lu_ready", 32'(id_ready), 32'd0);
        @(posedge clk); #1;
        chk("lu_bubble", 32'(ex_bubble), 32'd1);
        chk("lu_stall_clr", 32'(load_use_stall), 32'd0);
        chk("lu_fwd_mem", 32'(fwd_rs_sel), 32'd2);
        chk("lu_ready_back", 32'(id_ready), 32'd1);
        idle();

        // Mul hold with WB drain: add x1, then mul x10
        do_reset();
        fire(5'd1, 1'b1, 1'b0, 1'b0);
        fire(5'd10, 1'b1, 1'b0, 1'b1);
        present(5'd1, 1'b1, 5'd10, 1'b1);
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!muldiv_busy) break;
            chk($sformatf("md_ready_c%0d", c), 32'(id_ready), 32'd0);
            if (c == 0) chk("md_fwd_mem", 32'(fwd_rs_sel), 32'd2);
            if (c == 1) chk("md_fwd_wb", 32'(fwd_rs_sel), 32'd3);
            if (c == 2) chk("md_fwd_drained", 32'(fwd_rs_sel), 32'd0);
            if (c == 3) chk("md_fwd_ex_held", 32'(fwd_rt_sel), 32'd1);
            busy_cycles++;
            @(posedge clk);
        end
        chk("md_busy_cycles", 32'(busy_cycles), 32'd7);
        chk("md_ready_after", 32'(id_ready), 32'd1);
        idle();

        // Flush on the same cycle a div fires
        do_reset();
        idle();
        id_valid = 1; id_rd = 5'd12; id_reg_w_en = 1; id_is_muldiv = 1; flush = 1;
        @(posedge clk); #1;
        idle();
        chk("fl_busy", 32'(muldiv_busy), 32'd0);
        chk("fl_bubble", 32'(ex_bubble), 32'd1);

        // Flush while a mul is already counting does not cancel it
        fire(5'd13, 1'b1, 1'b0, 1'b1);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("fl_md_busy", 32'(muldiv_busy), 32'd1);
        chk("fl_md_ex_held", 32'(ex_bubble), 32'd0);

        // Reset three cycles into a mul hold
        do_reset();
        fire(5'd10, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rm_busy_pre", 32'(muldiv_busy), 32'd1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        present(5'd10, 1'b1, 5'd10, 1'b1);
        #1;
        chk("rm_busy", 32'(muldiv_busy), 32'd0);
        chk("rm_bubble", 32'(ex_bubble), 32'd1);
        chk("rm_fwd_rs", 32'(fwd_rs_sel), 32'd0);
        chk("rm_fwd_rt", 32'(fwd_rt_sel), 32'd0);
`ifdef YSYX_22041071_HAZARD_PERF_EN
        chk("rm_perf_lu", perf_lu_cnt, 32'd0);
        chk("rm_perf_md", perf_md_cnt, 32'd0);
`endif
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_hazard_unit.md
Name: ysyx_22041071_hazard_unit

Overview:
Pipeline hazard controller between the ID stage and the EX/MEM/WB stages of the RV64 core. It keeps a shadow scoreboard of the destination registers held in EX, MEM and WB. From it, the block generates the ID ready signal, the operand-forwarding selects, load-use stalls and multi-cycle mul/div hold cycles. All ID-to-EX sequencing decisions come from this block.

Parameters:
MULDIV_LAT, 8, EX occupancy in cycles for any mul/div instruction (ALU_ctrl 19..30); legal range 1..16.
CNT_W, 4, width of the mul/div hold counter; must satisfy 2^CNT_W >= MULDIV_LAT.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a valid instruction
id_rs  input  5  source register 1 index
id_rt  input  5  source register 2 index
id_use_rs  input  1  instruction reads rs
id_use_rt  input  1  instruction reads rt
id_rd  input  5  destination register index
id_reg_w_en  input  1  instruction writes rd
id_is_load  input  1  opcode is 0000011
id_is_muldiv  input  1  M-extension instruction
ex_ready  input  1  EX/downstream can accept
flush  input  1  redirect from EX; kills the instruction leaving ID this cycle
id_ready  output  1  ID may hand off (combinational)
id_fire  output  1  id_valid & id_ready
fwd_rs_sel  output  2  0 regfile, 1 EX result, 2 MEM data, 3 WB data
fwd_rt_sel  output  2  same encoding as fwd_rs_sel
load_use_stall  output  1  combinational load-use hazard indication
muldiv_busy  output  1  EX is held by a mul/div (registered)
ex_bubble  output  1  EX slot holds no valid instruction (registered)

Behaviour:
- Shadow slots EX, MEM, WB; each slot holds {v, rd, wen, ld}. A slot counts as "writing" only when v & wen & rd != 0.
- Reset: all slots have v=0; hold counter = 0. Outputs after reset: muldiv_busy=0, ex_bubble=1, fwd sels=0, load_use_stall=0.
- load_use_stall = id_valid & EX writing & EX.ld & ((id_use_rs & id_rs==EX.rd) | (id_use_rt & id_rt==EX.rd)).
- id_ready = ex_ready & ~load_use_stall & ~muldiv_busy.
- Forwarding, evaluated per source with priority EX > MEM > WB > regfile:
  - EX is selected only when it is writing, is not a load, and its rd matches the source.
  - An unused source, or index 0, always yields sel 0.
- Mul/div hold counter:
  - On id_fire & id_is_muldiv & ~flush, the counter loads MULDIV_LAT-1.
  - While the counter is nonzero it decrements each cycle. muldiv_busy = (counter != 0), registered.
  - With MULDIV_LAT=1 there is never a hold.
- Slot advance each cycle, when not held:
  - WB <= MEM; MEM <= EX.
  - EX <= ID entry if id_fire & ~flush; otherwise EX becomes a bubble (v=0).
- Slot advance while muldiv_busy:
  - EX holds its contents.
  - MEM <= bubble; WB <= MEM.
- ex_bubble = ~EX.v, registered.
- Simultaneous events:
  - flush together with a load-use stall: no fire, EX becomes a bubble.
  - flush does not cancel a mul/div already counting in EX.
  - ex_ready=0 with no hold: the whole shadow still advances and EX becomes a bubble. This mirrors the datapath, which inserts a bubble when no handshake occurs.
- Reset mid-operation: the counter and all slots clear in the same cycle; muldiv_busy=0 on the next cycle.

Optional Feature:
Macro YSYX_22041071_HAZARD_PERF_EN.
- Defined: adds output ports perf_lu_cnt[31:0] and perf_md_cnt[31:0].
  - perf_lu_cnt increments on each cycle with id_valid & load_use_stall.
  - perf_md_cnt increments on each cycle with muldiv_busy.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use stall:
  - Stimulus: ld x5 fires; next cycle ID presents add x6,x5,x7 (use_rs=1, rs=5).
  - Response: load_use_stall=1, id_ready=0 for 1 cycle, then ex_bubble=1; on the following cycle fwd_rs_sel=2.
- EX forwarding:
  - Stimulus: add x3 fires; next cycle ID presents sub x4,x3,x3.
  - Response: fwd_rs_sel=1 and fwd_rt_sel=1, no stall.
- x0 never forwarded:
  - Stimulus: addi x0 fires; next cycle ID reads rs=0.
  - Response: fwd_rs_sel=0.
- Mul/div hold:
  - Stimulus: mul fires with MULDIV_LAT=8.
  - Response: muldiv_busy=1 for exactly 7 cycles; id_ready=0 during those cycles; WB slot drains within 2 cycles.
- Flush:
  - Stimulus: flush=1 in the same cycle as id_fire of div.
  - Response: counter stays 0, muldiv_busy=0, ex_bubble=1 next cycle.
- Reset mid-operation:
  - Stimulus: reset asserted 3 cycles into a mul hold.
  - Response: next cycle muldiv_busy=0, ex_bubble=1, fwd sels=0. With YSYX_22041071_HAZARD_PERF_EN defined, both counters read 0.
